// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release (peripheral, memory, core) with soft-reset re-sequencing
// Asynchronous assertion, synchronized release; every output comes straight from a flop.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       soft_req,
  output logic       sys_resetn,
  output logic       mem_resetn,
  output logic       core_resetn,
  output logic       ready,
  output logic [1:0] cause,
  output logic [7:0] soft_count
);

  localparam int CMAX = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_STRETCH = 3'd1,
    S_GAP1    = 3'd2,
    S_GAP2    = 3'd3,
    S_RUN     = 3'd4,
    S_SOFT    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sys_q, sys_d;
  logic                   mem_q, mem_d;
  logic                   core_q, core_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;
  logic [7:0]             soft_count_q, soft_count_d;

  always_comb begin
    sync_d       = (sync_q << 1) | {{(SYNC_STAGES-1){1'b0}}, 1'b1};
    state_d      = state_q;
    cnt_d        = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    sys_d        = sys_q;
    mem_d        = mem_q;
    core_d       = core_q;
    ready_d      = ready_q;
    cause_d      = cause_q;
    soft_count_d = soft_count_q;

    case (state_q)
      // Leave SYNC on the same edge the last synchronizer stage loads its 1.
      S_SYNC: begin
        cnt_d = '0;
        if (sync_d[SYNC_STAGES-1]) begin
          state_d = S_STRETCH;
        end
      end
      S_STRETCH: begin
        if (cnt_q == STRETCH_LAST) begin
          state_d = S_GAP1;
          cnt_d   = '0;
          sys_d   = 1'b1;
        end
      end
      S_GAP1: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_GAP2;
          cnt_d   = '0;
          mem_d   = 1'b1;
        end
      end
      S_GAP2: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          core_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (soft_req) begin
          state_d = S_SOFT;
          mem_d   = 1'b0;
          core_d  = 1'b0;
          ready_d = 1'b0;
          cause_d = 2'b10;
          if (soft_count_q != 8'hFF) begin
            soft_count_d = soft_count_q + 8'd1;
          end
        end
      end
      // Peripherals stay up; GAP1 then only has the memory release left to do.
      S_SOFT: begin
        if (cnt_q == STRETCH_LAST) begin
          state_d = S_GAP1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q       <= '0;
      state_q      <= S_SYNC;
      cnt_q        <= '0;
      sys_q        <= 1'b0;
      mem_q        <= 1'b0;
      core_q       <= 1'b0;
      ready_q      <= 1'b0;
      cause_q      <= 2'b01;
      soft_count_q <= 8'd0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_q        <= sys_d;
      mem_q        <= mem_d;
      core_q       <= core_d;
      ready_q      <= ready_d;
      cause_q      <= cause_d;
      soft_count_q <= soft_count_d;
    end
  end

  assign sys_resetn  = sys_q;
  assign mem_resetn  = mem_q;
  assign core_resetn = core_q;
  assign ready       = ready_q;
  assign cause       = cause_q;
  assign soft_count  = soft_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - bench for reset_sequencer, default and minimum-timing instances
module tb_reset_sequencer;

  localparam int NI = 2;
  localparam int P_S  [NI] = '{2, 3};
  localparam int P_ST [NI] = '{16, 1};
  localparam int P_G  [NI] = '{4, 1};

  logic       clk;
  logic       resetn;
  logic       soft_req;
  logic       sys_o  [NI];
  logic       mem_o  [NI];
  logic       core_o [NI];
  logic       rdy_o  [NI];
  logic [1:0] cause_o[NI];
  logic [7:0] cnt_o  [NI];

  int vectors;
  int miscompares;

  reset_sequencer #(.SYNC_STAGES(2), .STRETCH(16), .STAGE_GAP(4)) u_dut0 (
    .clk(clk), .resetn(resetn), .soft_req(soft_req),
    .sys_resetn(sys_o[0]), .mem_resetn(mem_o[0]), .core_resetn(core_o[0]),
    .ready(rdy_o[0]), .cause(cause_o[0]), .soft_count(cnt_o[0])
  );

  reset_sequencer #(.SYNC_STAGES(3), .STRETCH(1), .STAGE_GAP(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .soft_req(soft_req),
    .sys_resetn(sys_o[1]), .mem_resetn(mem_o[1]), .core_resetn(core_o[1]),
    .ready(rdy_o[1]), .cause(cause_o[1]), .soft_count(cnt_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Schedule model: each domain releases at a fixed edge number counted from
  // the last hard release; a soft request taken while the core is up pushes
  // the mem/core release edges out from the request edge.
  int m_edge   [NI];
  int m_sys_at [NI];
  int m_mem_at [NI];
  int m_core_at[NI];
  int m_cause  [NI];
  int m_count  [NI];
  bit m_sys    [NI];
  bit m_mem    [NI];
  bit m_core   [NI];

  always @(posedge clk or negedge resetn) begin
    for (int i = 0; i < NI; i++) begin
      if (!resetn) begin
        m_edge[i]    = 0;
        m_sys_at[i]  = P_S[i] + P_ST[i];
        m_mem_at[i]  = m_sys_at[i] + P_G[i];
        m_core_at[i] = m_mem_at[i] + P_G[i];
        m_cause[i]   = 1;
        m_count[i]   = 0;
        m_sys[i]     = 1'b0;
        m_mem[i]     = 1'b0;
        m_core[i]    = 1'b0;
      end else begin
        m_edge[i] = m_edge[i] + 1;
        if (m_core[i] && soft_req) begin
          m_mem_at[i]  = m_edge[i] + P_ST[i] + P_G[i];
          m_core_at[i] = m_edge[i] + P_ST[i] + 2 * P_G[i];
          m_cause[i]   = 2;
          if (m_count[i] < 255) m_count[i] = m_count[i] + 1;
        end
        m_sys[i]  = (m_edge[i] >= m_sys_at[i]);
        m_mem[i]  = (m_edge[i] >= m_mem_at[i]);
        m_core[i] = (m_edge[i] >= m_core_at[i]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("m_sys%0d", i),   sys_o[i],   m_sys[i]);
      chk($sformatf("m_mem%0d", i),   mem_o[i],   m_mem[i]);
      chk($sformatf("m_core%0d", i),  core_o[i],  m_core[i]);
      chk($sformatf("m_ready%0d", i), rdy_o[i],   m_core[i]);
      chk($sformatf("m_cause%0d", i), cause_o[i], m_cause[i]);
      chk($sformatf("m_count%0d", i), cnt_o[i],   m_count[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string nm);
    for (int i = 0; i < NI; i++) begin
      chk({nm, "_sys"},   sys_o[i],   0);
      chk({nm, "_mem"},   mem_o[i],   0);
      chk({nm, "_core"},  core_o[i],  0);
      chk({nm, "_ready"}, rdy_o[i],   0);
      chk({nm, "_cause"}, cause_o[i], 1);
      chk({nm, "_count"}, cnt_o[i],   0);
    end
  endtask

  // Called just after resetn rises between edges; the next edge is edge 1.
  task automatic run_hard_checks(input string nm);
    for (int n = 1; n <= 30; n++) begin
      tick();
      chk({nm, "_sys0"},   sys_o[0],  n >= 18);
      chk({nm, "_mem0"},   mem_o[0],  n >= 22);
      chk({nm, "_core0"},  core_o[0], n >= 26);
      chk({nm, "_ready0"}, rdy_o[0],  n >= 26);
      chk({nm, "_sys1"},   sys_o[1],  n >= 4);
      chk({nm, "_mem1"},   mem_o[1],  n >= 5);
      chk({nm, "_core1"},  core_o[1], n >= 6);
    end
    chk({nm, "_cause0"}, cause_o[0], 1);
    chk({nm, "_count0"}, cnt_o[0],   0);
    chk({nm, "_cause1"}, cause_o[1], 1);
    chk({nm, "_count1"}, cnt_o[1],   0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    soft_req    = 1'b0;

    repeat (5) tick();
    chk_all_zero("por_low");
    resetn = 1'b1;
    run_hard_checks("por");

    // Single-cycle soft request
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("soft_sys0",   sys_o[0],   1);
    chk("soft_mem0",   mem_o[0],   0);
    chk("soft_core0",  core_o[0],  0);
    chk("soft_ready0", rdy_o[0],   0);
    chk("soft_cause0", cause_o[0], 2);
    chk("soft_count0", cnt_o[0],   1);
    chk("soft_mem1",   mem_o[1],   0);
    chk("soft_count1", cnt_o[1],   1);
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("soft_mem0_k",  mem_o[0],  k >= 20);
      chk("soft_core0_k", core_o[0], k >= 24);
      chk("soft_sys0_k",  sys_o[0],  1);
      chk("soft_mem1_k",  mem_o[1],  k >= 2);
      chk("soft_core1_k", core_o[1], k >= 3);
    end

    // Hard reset while dut0 is in SOFT
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    chk_all_zero("hr_soft");
    repeat (3) tick();
    resetn = 1'b1;
    run_hard_checks("after_soft_hr");

    // Hard reset while dut0 is in GAP1
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (20) tick();
    chk("gap1_sys0_up", sys_o[0], 1);
    resetn = 1'b0;
    #1;
    chk_all_zero("hr_gap1");
    repeat (2) tick();
    resetn = 1'b1;
    run_hard_checks("after_gap1_hr");

    // Sub-cycle resetn glitch
    resetn = 1'b0;
    #1;
    chk_all_zero("glitch");
    #1;
    resetn = 1'b1;
    run_hard_checks("after_glitch");

    // soft_req held high: re-trigger only on RUN cycles
    soft_req = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 1)  chk("held_first",  cnt_o[0], 1);
      if (k == 25) chk("held_gap",    cnt_o[0], 1);
      if (k == 26) chk("held_second", cnt_o[0], 2);
    end
    soft_req = 1'b0;
    repeat (30) tick();
    chk("held_total", cnt_o[0], 4);

    // Saturation
    for (int r = 0; r < 260; r++) begin
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      repeat (24) tick();
    end
    chk("sat_count0", cnt_o[0], 255);
    chk("sat_count1", cnt_o[1], 255);
    chk("sat_cause0", cause_o[0], 2);
    repeat (3) tick();
    chk("sat_hold0", cnt_o[0], 255);
    resetn = 1'b0;
    #1;
    chk_all_zero("sat_hr");
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
